multi_button_vote_ctrl: RTL and testbench

MULTI_BUTTON_VOTE_CTRL -- requirements
Module: multi_button_vote_ctrl

---
 rtl/vote_pkg.sv | 13 +
 rtl/button_debounce_ch.sv | 39 +++
 rtl/multi_button_vote_ctrl.sv | 108 ++++++++++
 tb/tb_multi_button_vote_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared constants and FSM state type for the multi-button vote controller.
package vote_pkg;

  localparam int unsigned NUM_CH_DEF          = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 10;
  localparam int unsigned TOTAL_W_DEF         = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } vote_state_e;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: counts consecutive high samples, saturating at DEBOUNCE_CYCLES.
module button_debounce_ch
  import vote_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic qualified
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any low sample restarts qualification.
  always_comb begin
    cnt_d = cnt_q;
    if (!button) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign qualified = (cnt_q == CNT_MAX);

endmodule

// File: rtl/multi_button_vote_ctrl.sv
// Debounced multi-button voting: accepts one qualified press per release cycle,
// rejects simultaneous presses, and keeps a saturating tally of accepted votes.
module multi_button_vote_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CH          = NUM_CH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TOTAL_W         = TOTAL_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         button,
  output logic                      vote_valid,
  output logic [$clog2(NUM_CH)-1:0] vote_idx,
  output logic                      conflict,
  output logic                      busy,
  output logic [TOTAL_W-1:0]        total_votes
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]  qual;
  logic               any_qual;
  logic               multi_qual;
  logic [IDX_W-1:0]   sel_idx_d;

  vote_state_e        state_q;
  logic               vote_valid_q;
  logic               conflict_q;
  logic               busy_q;
  logic [IDX_W-1:0]   vote_idx_q;
  logic [TOTAL_W-1:0] total_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .button    (button[g]),
      .qualified (qual[g])
    );
  end

  // Clearing the lowest set bit leaves something only if two or more are set.
  always_comb begin
    any_qual   = |qual;
    multi_qual = |(qual & (qual - NUM_CH'(1)));
    sel_idx_d  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (qual[i]) begin
        sel_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      vote_valid_q <= 1'b0;
      conflict_q   <= 1'b0;
      busy_q       <= 1'b0;
      vote_idx_q   <= '0;
      total_q      <= '0;
    end else begin
      vote_valid_q <= 1'b0;
      conflict_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A qualified press with the window closed is swallowed silently.
          if (any_qual) begin
            state_q <= WAIT_REL;
            busy_q  <= 1'b1;
            if (enable) begin
              if (multi_qual) begin
                conflict_q <= 1'b1;
              end else begin
                vote_valid_q <= 1'b1;
                vote_idx_q   <= sel_idx_d;
                if (total_q != '1) begin
                  total_q <= total_q + TOTAL_W'(1);
                end
              end
            end
          end
        end
        WAIT_REL: begin
          if (button == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vote_valid  = vote_valid_q;
  assign conflict    = conflict_q;
  assign busy        = busy_q;
  assign vote_idx    = vote_idx_q;
  assign total_votes = total_q;

endmodule

// File: tb/tb_multi_button_vote_ctrl.sv
// Scoreboard bench: each task queues the vote/conflict events its stimulus should cause.
module tb_multi_button_vote_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  button;
  logic        vote_valid;
  logic [1:0]  vote_idx;
  logic        conflict;
  logic        busy;
  logic [15:0] total_votes;
  logic        sat_vote_valid;
  logic [1:0]  sat_vote_idx;
  logic        sat_conflict;
  logic        sat_busy;
  logic [1:0]  sat_total;

  typedef struct {
    bit          is_conflict;
    logic [1:0]  idx;
    logic [15:0] total;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sat_pulses = 0;

  multi_button_vote_ctrl #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(10), .TOTAL_W(16)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .button(button),
    .vote_valid(vote_valid), .vote_idx(vote_idx), .conflict(conflict),
    .busy(busy), .total_votes(total_votes)
  );

  multi_button_vote_ctrl #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(10), .TOTAL_W(2)
  ) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .button(button),
    .vote_valid(sat_vote_valid), .vote_idx(sat_vote_idx), .conflict(sat_conflict),
    .busy(sat_busy), .total_votes(sat_total)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pop one expected event for every pulse the main instance produces.
  always @(negedge clock) begin
    if (!reset) begin
      if (sat_vote_valid) sat_pulses++;
      if (vote_valid || conflict) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got vote_valid=%0b conflict=%0b idx=%0d total=%0d, required no pulse",
                   vote_valid, conflict, vote_idx, total_votes);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({conflict, vote_valid, vote_idx, total_votes} !==
              {e.is_conflict, !e.is_conflict, e.idx, e.total}) begin
            n_err++;
            $display("FAIL scoreboard_event: got conflict=%0b vote_valid=%0b idx=%0d total=%0d, required conflict=%0b vote_valid=%0b idx=%0d total=%0d",
                     conflict, vote_valid, vote_idx, total_votes,
                     e.is_conflict, !e.is_conflict, e.idx, e.total);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    button = 4'b0;
    tick(2);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++;
    if ({vote_valid, conflict, busy, vote_idx, total_votes, sat_total} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got vv=%0b cf=%0b busy=%0b idx=%0d total=%0d sat_total=%0d, required all 0",
               vote_valid, conflict, busy, vote_idx, total_votes, sat_total);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_press();
    button[2] = 1'b1;
    exp_q.push_back('{1'b0, 2'd2, 16'd1});
    tick(10);
    n_cmp++;
    if (vote_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: vote_valid=%0b, required 0", vote_valid);
    end
    tick(1);
    n_cmp++;
    if ({vote_valid, busy, vote_idx, total_votes} !== {1'b1, 1'b1, 2'd2, 16'd1}) begin
      n_err++;
      $display("FAIL latency_pulse: vv=%0b busy=%0b idx=%0d total=%0d, required 1 1 2 1",
               vote_valid, busy, vote_idx, total_votes);
    end
    tick(1);
    n_cmp++;
    if (vote_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_width: vote_valid=%0b, required 0", vote_valid);
    end
    tick(3);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_held: busy=%0b, required 1", busy);
    end
    button[2] = 1'b0;
    tick(1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_release: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_glitch();
    button[1] = 1'b1; tick(9);
    button[1] = 1'b0; tick(1);
    button[1] = 1'b1; tick(9);
    button[1] = 1'b0; tick(3);
    n_cmp++;
    if ({busy, total_votes} !== {1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL glitch_no_vote: busy=%0b total=%0d, required 0 1", busy, total_votes);
    end
    button[1] = 1'b1;
    exp_q.push_back('{1'b0, 2'd1, 16'd2});
    tick(10);
    button[1] = 1'b0;
    tick(3);
    n_cmp++;
    if ({vote_idx, total_votes} !== {2'd1, 16'd2}) begin
      n_err++;
      $display("FAIL glitch_then_hold: idx=%0d total=%0d, required 1 2", vote_idx, total_votes);
    end
  endtask

  task automatic test_conflict();
    button = 4'b1001;
    exp_q.push_back('{1'b1, 2'd1, 16'd2});
    tick(12);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_busy: busy=%0b, required 1", busy);
    end
    button = 4'b0;
    tick(3);
    n_cmp++;
    if ({busy, vote_idx, total_votes} !== {1'b0, 2'd1, 16'd2}) begin
      n_err++;
      $display("FAIL conflict_state: busy=%0b idx=%0d total=%0d, required 0 1 2", busy, vote_idx, total_votes);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    button[2] = 1'b1;
    exp_q.push_back('{1'b0, 2'd2, 16'd1});
    tick(50);
    button[2] = 1'b0;
    tick(2);
    button[2] = 1'b1;
    exp_q.push_back('{1'b0, 2'd2, 16'd2});
    tick(10);
    button[2] = 1'b0;
    tick(3);
    n_cmp++;
    if ({busy, total_votes} !== {1'b0, 16'd2}) begin
      n_err++;
      $display("FAIL repress_total: busy=%0b total=%0d, required 0 2", busy, total_votes);
    end
  endtask

  task automatic test_disable_reset();
    enable = 1'b0;
    button[0] = 1'b1;
    tick(12);
    n_cmp++;
    if ({busy, total_votes} !== {1'b1, 16'd2}) begin
      n_err++;
      $display("FAIL disabled_swallow: busy=%0b total=%0d, required 1 2", busy, total_votes);
    end
    enable = 1'b1;
    tick(3);
    button[0] = 1'b0;
    tick(2);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL disabled_release: busy=%0b, required 0", busy);
    end
    button[3] = 1'b1;
    exp_q.push_back('{1'b0, 2'd3, 16'd3});
    tick(13);
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({vote_valid, conflict, busy, vote_idx, total_votes} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_wait_rel: vv=%0b cf=%0b busy=%0b idx=%0d total=%0d, required all 0",
               vote_valid, conflict, busy, vote_idx, total_votes);
    end
    reset = 1'b0;
    exp_q.push_back('{1'b0, 2'd3, 16'd1});
    tick(10);
    n_cmp++;
    if (vote_valid !== 1'b0) begin
      n_err++;
      $display("FAIL requalify_early: vote_valid=%0b, required 0", vote_valid);
    end
    tick(1);
    n_cmp++;
    if ({vote_valid, vote_idx} !== {1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL requalify_pulse: vv=%0b idx=%0d, required 1 3", vote_valid, vote_idx);
    end
    button[3] = 1'b0;
    tick(3);
  endtask

  task automatic test_saturation();
    do_reset();
    sat_pulses = 0;
    for (int v = 1; v <= 5; v++) begin
      button[1] = 1'b1;
      exp_q.push_back('{1'b0, 2'd1, 16'(v)});
      tick(10);
      button[1] = 1'b0;
      tick(3);
      if (v == 3) begin
        n_cmp++;
        if (sat_total !== 2'd3) begin
          n_err++;
          $display("FAIL sat_reach_max: sat_total=%0d, required 3", sat_total);
        end
      end
    end
    n_cmp++;
    if ({sat_total, total_votes} !== {2'd3, 16'd5}) begin
      n_err++;
      $display("FAIL sat_hold: sat_total=%0d total=%0d, required 3 5", sat_total, total_votes);
    end
    n_cmp++;
    if (sat_pulses !== 5) begin
      n_err++;
      $display("FAIL sat_pulses: got %0d, required 5", sat_pulses);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    button = 4'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_conflict();
    test_back_to_back();
    test_disable_reset();
    test_saturation();
    tick(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
